pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage LEGv8 pipeline registers (IF/ID, ID/EX, EX/MEM).
- Detects load-use hazards and holds PC and IF/ID while injecting ID/EX bubbles.
- Flushes IF/ID on a taken branch.
- Freezes the whole pipe while data memory reports busy.
- Keeps stall and flush event counters for performance debug.

Parameters:
LOAD_STALL, 1, stall cycles per load-use hazard (1..7)
FLUSH_CYCLES, 1, IF/ID flush cycles per taken branch (1..3)
CNT_W, 32, width of the stall and flush counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
Rn_id  in  5  ID-stage first source register
Rm_id  in  5  ID-stage second source register (Rd when Reg2Loc selects store data)
Rm_used_id  in  1  ID instruction reads its second source
Rd_ex  in  5  EX-stage destination register
MemtoReg_ex  in  1  EX instruction is a load
RegWrite_ex  in  1  EX instruction writes the register file
br_taken  in  1  branch resolved taken this cycle
dmem_busy  in  1  data memory not ready; pipe must hold
pc_en  out  1  PC register write enable
if_id_en  out  1  IF/ID enable
if_id_flush  out  1  IF/ID synchronous clear to NOP
id_ex_bubble  out  1  zero ID/EX control fields (RegWrite, MemWrite, branch)
pipe_en  out  1  enable for ID/EX and EX/MEM
stall_cnt  out  CNT_W  load-use stall cycles counted
flush_cnt  out  CNT_W  taken-branch flush events counted

Behaviour:
- States: RUN, LU_STALL, BR_FLUSH.
- Internal 3-bit down-counter `rem`.
- Reset (reset=0, async):
  - state=RUN, rem=0, stall_cnt=0, flush_cnt=0.
  - Outputs while in reset: pc_en=1, if_id_en=1, pipe_en=1, if_id_flush=0, id_ex_bubble=0.
- Hazard term: hz = MemtoReg_ex & RegWrite_ex & (Rd_ex != 31) & ((Rd_ex == Rn_id) | (Rm_used_id & (Rd_ex == Rm_id))).
  - X31 (XZR) never hazards.
- Outputs are Mealy, combinational from state and inputs.
- Priority, highest first: dmem_busy > br_taken > hazard.
- dmem_busy=1, in any state:
  - All enables 0; if_id_flush=0; id_ex_bubble=0.
  - state and rem hold; counters hold.
  - A br_taken or hz seen in this cycle is ignored. Upstream holds them stable, so they are re-evaluated after busy drops.
- RUN, br_taken=1:
  - pc_en=1, if_id_flush=1, pipe_en=1.
  - flush_cnt += 1.
  - If FLUSH_CYCLES>1: go to BR_FLUSH with rem=FLUSH_CYCLES-1.
  - A simultaneous hz is dropped, because the younger instruction is flushed.
- RUN, hz=1 (no branch):
  - pc_en=0, if_id_en=0, id_ex_bubble=1, pipe_en=1.
  - stall_cnt += 1.
  - If LOAD_STALL>1: go to LU_STALL with rem=LOAD_STALL-1.
- RUN, neither: all enables 1, no flush, no bubble.
- LU_STALL:
  - Same outputs as RUN+hz; stall_cnt += 1; rem -= 1.
  - When rem==1, return to RUN next cycle.
  - br_taken=1 here: aborts the stall. Same cycle gives if_id_flush=1, pc_en=1, flush_cnt += 1. Next state is BR_FLUSH (or RUN if FLUSH_CYCLES==1).
- BR_FLUSH:
  - if_id_flush=1, pc_en=1, pipe_en=1; rem -= 1.
  - When rem==1, go to RUN.
  - A new br_taken here reloads rem=FLUSH_CYCLES-1 and increments flush_cnt.
- Counters wrap modulo 2^CNT_W.
- Reset mid-stall or mid-flush: immediate return to RUN with the reset output values.
- Latency: hazard and flush responses appear in the same cycle as the triggering inputs (no register delay).

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum (RUN, LU_STALL, BR_FLUSH).
  - XZR_IDX = 5'd31.
  - Default LOAD_STALL / FLUSH_CYCLES constants.
- One sub-module, hazard_detect: combinational hz term, reusable by the forwarding unit.
- Counters are inline registers; the n_dff used elsewhere has a synchronous reset, so it is not used here.

Test Plan:
1. Load-use: MemtoReg_ex=1, RegWrite_ex=1, Rd_ex=5, Rn_id=5, LOAD_STALL=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cnt=1; RUN next cycle.
2. XZR and unused Rm: Rd_ex=31 matching Rn_id=31 -> no stall. Rd_ex=7, Rm_id=7, Rm_used_id=0 -> no stall.
3. Branch during stall: LOAD_STALL=3, hz, then br_taken in cycle 2 -> cycle 2 if_id_flush=1, pc_en=1; stall_cnt=2, flush_cnt=1.
4. Memory freeze: dmem_busy=1 for 4 cycles while in LU_STALL with rem=2 -> all enables 0 for 4 cycles; counters unchanged; stall resumes with 2 cycles left.
5. Simultaneous br_taken and hz in RUN -> flush only; stall_cnt=0, flush_cnt=1.
6. Async reset (reset=0) mid BR_FLUSH (FLUSH_CYCLES=3) between clock edges -> outputs return to run values immediately; counters 0; RUN after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared controller states, XZR index and default stall/flush lengths
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, LU_STALL, BR_FLUSH} state_e;
  localparam logic [4:0] XZR_IDX = 5'd31;
  localparam int LOAD_STALL_DEF = 1;
  localparam int FLUSH_CYCLES_DEF = 1;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between EX-stage load and ID-stage sources
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_rn,
  input  logic [4:0] i_rm,
  input  logic       i_rm_used,
  input  logic [4:0] i_rd,
  input  logic       i_mem_to_reg,
  input  logic       i_reg_write,
  output logic       o_hz
);
  assign o_hz = i_mem_to_reg & i_reg_write & (i_rd != XZR_IDX) &
                ((i_rd == i_rn) | (i_rm_used & (i_rd == i_rm)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and memory freeze sequencing
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL   = LOAD_STALL_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rn_id,
  input  logic [4:0]       Rm_id,
  input  logic             Rm_used_id,
  input  logic [4:0]       Rd_ex,
  input  logic             MemtoReg_ex,
  input  logic             RegWrite_ex,
  input  logic             br_taken,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [2:0] LS_REM = 3'(LOAD_STALL - 1);
  localparam logic [2:0] FL_REM = 3'(FLUSH_CYCLES - 1);
  state_e           r_state, w_state_nxt;
  logic [2:0]       r_rem, w_rem_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_hz, w_stall_inc, w_flush_inc;
  hazard_detect u_hd (
    .i_rn(Rn_id),
    .i_rm(Rm_id),
    .i_rm_used(Rm_used_id),
    .i_rd(Rd_ex),
    .i_mem_to_reg(MemtoReg_ex),
    .i_reg_write(RegWrite_ex),
    .o_hz(w_hz)
  );
  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_en      = 1'b1;
    // while reset is held the outputs stay at their run values regardless of inputs
    if (!reset) w_state_nxt = RUN;
    else if (dmem_busy) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      pipe_en  = 1'b0;
    end else if (br_taken) begin
      if_id_flush = 1'b1;
      w_flush_inc = 1'b1;
      w_state_nxt = FLUSH_CYCLES > 1 ? BR_FLUSH : RUN;
      w_rem_nxt   = FL_REM;
    end else if (r_state == BR_FLUSH) begin
      if_id_flush = 1'b1;
      w_rem_nxt   = r_rem - 3'd1;
      w_state_nxt = r_rem == 3'd1 ? RUN : BR_FLUSH;
    end else if (r_state == LU_STALL || w_hz) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      w_stall_inc  = 1'b1;
      w_rem_nxt    = r_state == LU_STALL ? r_rem - 3'd1 : LS_REM;
      w_state_nxt  = r_state == LU_STALL ? (r_rem == 3'd1 ? RUN : LU_STALL)
                                         : (LOAD_STALL > 1 ? LU_STALL : RUN);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_rem       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, w_stall_inc};
      r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, w_flush_inc};
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: two parameterisations driven in parallel, scoreboarded against a cycle-level model
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] rn = '0, rm = '0, rd = '0;
  logic used = 1'b0, mtr = 1'b0, rw = 1'b0, br = 1'b0, busy = 1'b0;
  logic a_pc, a_ife, a_fl, a_bub, a_pe, b_pc, b_ife, b_fl, b_bub, b_pe;
  logic [31:0] a_sc, a_fc;
  logic [2:0] b_sc, b_fc;
  typedef struct {
    logic [4:0] a_o;
    int a_s;
    int a_f;
    logic [4:0] b_o;
    int b_s;
    int b_f;
  } exp_t;
  exp_t q[$];
  exp_t e_mon;
  int total = 0, bad = 0;
  int sl[2] = '{0, 0};
  int fl[2] = '{0, 0};
  int sc[2] = '{0, 0};
  int fc[2] = '{0, 0};
  int ls_p[2] = '{3, 1};
  int fc_p[2] = '{3, 1};
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(3), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .Rn_id(rn), .Rm_id(rm), .Rm_used_id(used), .Rd_ex(rd),
    .MemtoReg_ex(mtr), .RegWrite_ex(rw), .br_taken(br), .dmem_busy(busy),
    .pc_en(a_pc), .if_id_en(a_ife), .if_id_flush(a_fl), .id_ex_bubble(a_bub), .pipe_en(a_pe),
    .stall_cnt(a_sc), .flush_cnt(a_fc)
  );
  pipe_hazard_ctrl #(.LOAD_STALL(1), .FLUSH_CYCLES(1), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .Rn_id(rn), .Rm_id(rm), .Rm_used_id(used), .Rd_ex(rd),
    .MemtoReg_ex(mtr), .RegWrite_ex(rw), .br_taken(br), .dmem_busy(busy),
    .pc_en(b_pc), .if_id_en(b_ife), .if_id_flush(b_fl), .id_ex_bubble(b_bub), .pipe_en(b_pe),
    .stall_cnt(b_sc), .flush_cnt(b_fc)
  );
  // output vector order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}
  task automatic model(input int k, input bit hz, output logic [4:0] o, output int s, output int f);
    s = sc[k];
    f = fc[k];
    if (busy) o = 5'b00000;
    else if (br) begin
      o = 5'b11101; fc[k]++; fl[k] = fc_p[k] - 1; sl[k] = 0;
    end else if (fl[k] > 0) begin
      o = 5'b11101; fl[k]--;
    end else if (sl[k] > 0) begin
      o = 5'b00011; sc[k]++; sl[k]--;
    end else if (hz) begin
      o = 5'b00011; sc[k]++; sl[k] = ls_p[k] - 1;
    end else o = 5'b11001;
  endtask
  task automatic drive(input logic [4:0] i_rn, input logic [4:0] i_rm, input logic [4:0] i_rd,
                       input logic i_used, input logic i_mtr, input logic i_rw,
                       input logic i_br, input logic i_busy);
    exp_t e;
    bit hz;
    @(posedge clk);
    #1;
    reset = 1'b1;
    rn = i_rn; rm = i_rm; rd = i_rd; used = i_used;
    mtr = i_mtr; rw = i_rw; br = i_br; busy = i_busy;
    hz = mtr && rw && rd != 5'd31 && (rd == rn || (used && rd == rm));
    model(0, hz, e.a_o, e.a_s, e.a_f);
    model(1, hz, e.b_o, e.b_s, e.b_f);
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #2;
    reset = 1'b0;
    sl = '{0, 0}; fl = '{0, 0}; sc = '{0, 0}; fc = '{0, 0};
    e.a_o = 5'b11001; e.a_s = 0; e.a_f = 0;
    e.b_o = 5'b11001; e.b_s = 0; e.b_f = 0;
    q.push_back(e);
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e_mon = q.pop_front();
      chk("a_ctl", 32'({a_pc, a_ife, a_fl, a_bub, a_pe}), 32'(e_mon.a_o));
      chk("a_stall_cnt", a_sc, 32'(e_mon.a_s));
      chk("a_flush_cnt", a_fc, 32'(e_mon.a_f));
      chk("b_ctl", 32'({b_pc, b_ife, b_fl, b_bub, b_pe}), 32'(e_mon.b_o));
      chk("b_stall_cnt", 32'(b_sc), 32'(e_mon.b_s) & 32'd7);
      chk("b_flush_cnt", 32'(b_fc), 32'(e_mon.b_f) & 32'd7);
    end
  end
  function automatic logic [4:0] pick();
    int r = $urandom_range(0, 4);
    return r == 4 ? 5'd31 : 5'(r);
  endfunction
  initial begin
    do_reset();
    drive(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    drive(5'd31, 5'd0, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(5'd0, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    drive(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    drive(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    drive(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    do_reset();
    idle(2);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else drive(pick(), pick(), pick(), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
